// File: rtl/mycpu_pkg.sv
// Shared defaults and constants for the regfile/scoreboard slice.
package mycpu_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_RD_DEF = 2;
   localparam int CNT_W_DEF  = 2;
   // Architectural zero register index.
   localparam int REG_ZERO   = 0;
endpackage

// File: rtl/mycpu_regfile_sb_if.sv
// Decode/writeback-facing bus of the register file with scoreboard.
interface mycpu_regfile_sb_if
   import mycpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = NUM_RD_DEF
) ();
   logic [NUM_RD*ADDR_W-1:0] raddr;
   logic [NUM_RD*DATA_W-1:0] rdata;
   logic [NUM_RD-1:0]        rbusy;
   logic                     wen;
   logic [ADDR_W-1:0]        waddr;
   logic [DATA_W-1:0]        wdata;
   logic                     rsv_valid;
   logic [ADDR_W-1:0]        rsv_addr;
   logic                     rsv_ready;
   logic                     flush;
   logic                     any_busy;

   modport master (
      output raddr, wen, waddr, wdata, rsv_valid, rsv_addr, flush,
      input  rdata, rbusy, rsv_ready, any_busy
   );

   modport slave (
      input  raddr, wen, waddr, wdata, rsv_valid, rsv_addr, flush,
      output rdata, rbusy, rsv_ready, any_busy
   );
endinterface

// File: rtl/mycpu_sb_cnt.sv
// Saturating up/down pending-write counter for one register.
module mycpu_sb_cnt
   import mycpu_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             nz_o
);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear dominates; simultaneous inc and dec cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_i && !inc_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign nz_o  = (cnt_q != '0);
endmodule

// File: rtl/mycpu_regfile_sb.sv
// Register file with same-cycle write bypass and per-register pending-write
// scoreboard used by decode for RAW stalls and WAW tracking.
module mycpu_regfile_sb
   import mycpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = NUM_RD_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   mycpu_regfile_sb_if.slave  bus
);
   localparam int NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0]            regs_q [NREG];
   logic [NREG-1:0][CNT_W-1:0]   cnt_w;
   logic [NREG-1:0]              nz_w;
   logic                         rsv_ready_w;

   // Data array; register 0 is never written and so always holds zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      end else if (bus.wen && (bus.waddr != ZERO_A)) begin
         regs_q[bus.waddr] <= bus.wdata;
      end
   end

   // A saturated destination can still be reserved if a writeback to it
   // frees a slot in the same cycle.
   assign rsv_ready_w = (bus.rsv_addr == ZERO_A)
                     || !(&cnt_w[bus.rsv_addr])
                     || (bus.wen && (bus.waddr == bus.rsv_addr));
   assign bus.rsv_ready = rsv_ready_w;

   assign cnt_w[0] = '0;
   assign nz_w[0]  = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi++) begin : g_cnt
         logic inc;
         logic dec;
         assign inc = bus.rsv_valid && rsv_ready_w && (bus.rsv_addr == ADDR_W'(gi));
         assign dec = bus.wen && (bus.waddr == ADDR_W'(gi)) && nz_w[gi];
         mycpu_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (inc),
            .dec_i (dec),
            .clr_i (bus.flush),
            .cnt_o (cnt_w[gi]),
            .nz_o  (nz_w[gi])
         );
      end

      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] ra;
         logic [CNT_W-1:0]  rc;
         logic [CNT_W-1:0]  rel;
         logic              hit;
         assign ra  = bus.raddr[gi*ADDR_W +: ADDR_W];
         assign rc  = cnt_w[ra];
         assign hit = bus.wen && (bus.waddr == ra);
         // A writeback releasing the last pending write clears busy now,
         // matching the bypassed data.
         assign rel = (hit && (rc != '0)) ? CNT_W'(1) : '0;
         assign bus.rdata[gi*DATA_W +: DATA_W] = (ra == ZERO_A) ? '0
                                              : hit ? bus.wdata
                                              : regs_q[ra];
         assign bus.rbusy[gi] = (ra != ZERO_A) && ((rc - rel) != '0);
      end
   endgenerate

   assign bus.any_busy = |nz_w;
endmodule

// File: doc/mycpu_regfile_sb.md
Name: mycpu_regfile_sb

Overview:
Parametrised register file with an integrated write scoreboard, the next-generation operand source for the decode stage. It provides NUM_RD combinational read ports with same-cycle write bypass. A per-register pending-write counter lets decode detect RAW hazards and stall. Decode reserves a destination register at issue; writeback releases it. The counters allow several in-flight writes to the same register (WAW).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; 2**ADDR_W registers, register 0 hardwired to zero
NUM_RD, 2, number of read ports
CNT_W, 2, pending-counter width; max in-flight writes per register = 2**CNT_W-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
raddr  in  NUM_RD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data; port i is bits [i*DATA_W +: DATA_W]
rbusy  out  NUM_RD  port i operand still has a pending write
wen  in  1  writeback valid
waddr  in  ADDR_W  writeback register
wdata  in  DATA_W  writeback data
rsv_valid  in  1  issue requests a reservation of rsv_addr
rsv_addr  in  ADDR_W  destination to reserve
rsv_ready  out  1  reservation can be accepted this cycle
flush  in  1  pipeline flush: drop all pending reservations
any_busy  out  1  at least one counter is non-zero

Behaviour:
- Reset (rst=0, async): all registers become 0 and all counters become 0. Outputs then read rdata=0, rbusy=0, rsv_ready=1, any_busy=0.
- Reads are combinational.
  - rdata[i] = 0 if raddr[i]==0.
  - Otherwise rdata[i] = wdata if wen && waddr==raddr[i] (bypass).
  - Otherwise rdata[i] = the stored value.
- Write: on the clk edge with wen=1 and waddr!=0, store wdata. Writes to register 0 are ignored.
- Counter cnt[r] update per edge:
  - inc = rsv_valid && rsv_ready && rsv_addr==r && r!=0.
  - dec = wen && waddr==r && cnt[r]!=0.
  - inc&dec: cnt unchanged. inc only: +1. dec only: -1.
  - A writeback to a register with cnt=0 stores data; cnt stays 0 (no underflow).
- rbusy[i] = 0 if raddr[i]==0.
  - Otherwise rbusy[i] = (cnt[raddr[i]] - (wen && waddr==raddr[i] && cnt!=0)) != 0.
  - So a writeback that releases the last pending write clears busy in the same cycle, consistent with the bypass.
- rsv_ready:
  - 1 if rsv_addr==0.
  - Otherwise 0 only when cnt[rsv_addr] is saturated (all ones) and there is no same-cycle writeback to rsv_addr.
  - rsv_ready does not depend on rsv_valid.
- flush=1:
  - All counters are 0 after the edge.
  - Any same-cycle reservation is discarded; flush wins over inc and dec.
  - A same-cycle writeback still writes data.
  - rbusy/rsv_ready in the flush cycle are computed normally from the current counters.
- any_busy = OR over all counters (registered state, no combinational path from inputs).
- Reset asserted mid-operation clears data and counters immediately. In-flight writebacks are lost.
- No other latency: reads 0 cycles, writes and counter updates visible from the next cycle.

Decomposition:
- Shared package mycpu_pkg: DATA_W and ADDR_W defaults, REG_ZERO constant (0), CNT_W default.
- Sub-module mycpu_sb_cnt: a single saturating up/down counter with inc, dec, clr and a non-zero flag. Instantiated for registers 1..2**ADDR_W-1.
- Data array and bypass/read muxes stay in the top module.

Test Plan:
- Reset, then read r5 and r0 → rdata=0, rbusy=0, rsv_ready=1, any_busy=0. Apply wen to r0 with 0xDEADBEEF → r0 still reads 0.
- Reserve r3 at cycle 1; r3 busy from cycle 2. Writeback r3=0x12345678 at cycle 4 → in cycle 4 rdata=0x12345678 (bypass), rbusy=0. In cycle 5 rdata is unchanged and any_busy=0.
- Reserve r7 three times (CNT_W=2) → rsv_ready=0. A fourth rsv_valid is ignored. Add a same-cycle writeback to r7 → rsv_ready=1, count stays 3.
- Reserve r9 twice, then writeback r9 once → rbusy stays 1. Second writeback → rbusy=0 in that cycle.
- Reserve r2 and r4, then flush with a simultaneous rsv r6 and writeback r2=0xA5 → after the edge all busy=0, r6 not reserved, r2 reads 0xA5.
- Reserve r10, then pulse rst low asynchronously between clock edges → rdata=0, counters 0, any_busy=0 immediately, without waiting for a clk edge.
